// File: rtl/sync_timing_rx.sv
// sync_timing_rx
// Receive-side raster timing recovery. Watches the HLOCK/VLOCK/SYNC_ACT stream,
// measures line/frame totals and the active window in both axes, qualifies the
// timing over consecutive frames and reports LOCKED plus error statistics.
// Optional build macro: SYNC_CRC_EN adds a CRC-16-CCITT over the active pixels
// (reported on M_CRC and used in the match compare while locked). Without it
// M_CRC is tied to zero and no CRC logic is built.
module sync_timing_rx #(
    parameter int LOCK_FRAMES = 2,
    parameter int HTO         = 4095
) (
    input  logic        PCK,
    input  logic        RST,
    input  logic        HLOCK,
    input  logic        VLOCK,
    input  logic        SYNC_ACT,
    input  logic [9:0]  SYNC_DO,
    output logic [11:0] M_HTW,
    output logic [10:0] M_VTW,
    output logic [11:0] M_HSP,
    output logic [11:0] M_HW,
    output logic [10:0] M_VSP,
    output logic [10:0] M_VW,
    output logic        FRAME_DONE,
    output logic        LOCKED,
    output logic [7:0]  ERR_CNT,
    output logic        TIMEOUT,
    output logic [15:0] M_CRC
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_MEASURE = 2'd1,
        S_VERIFY  = 2'd2,
        S_LOCKED  = 2'd3
    } state_t;

    // Position / timeout counters
    logic [11:0] hpos_reg;
    logic [10:0] vpos_reg;
    logic [15:0] to_cnt_reg;

    // Per-line capture
    logic [11:0] line_hsp_reg;
    logic [11:0] line_hw_reg;
    logic [11:0] cur_hsp;
    logic [11:0] cur_hw;
    logic [11:0] line_total;

    // Per-frame accumulators and their values after folding in the current line
    logic        fr_seen_reg;
    logic [11:0] fr_lt_reg;
    logic        fr_act_reg;
    logic [11:0] fr_hsp_reg;
    logic [11:0] fr_hw_reg;
    logic [10:0] fr_vsp_reg;
    logic [10:0] fr_vw_reg;
    logic        fr_incons_reg;

    logic [11:0] a_lt;
    logic        a_act;
    logic [11:0] a_hsp;
    logic [11:0] a_hw;
    logic [10:0] a_vsp;
    logic [10:0] a_vw;
    logic        a_incons;

    // Frame result as seen on the VLOCK cycle
    logic [11:0] fin_htw;
    logic [10:0] fin_vtw;
    logic [15:0] fin_crc;
    logic        frame_end;
    logic        frame_eq;
    logic        crc_eq;

    // Qualification FSM
    state_t      state_reg, state_next;
    logic [3:0]  match_reg, match_next;
    logic [7:0]  err_reg, err_next;
    logic        timeout_reg, timeout_next;
    logic        ref_load;
    logic        upd_m;
    logic        timeout_hit;

    logic [11:0] ref_htw_reg;
    logic [10:0] ref_vtw_reg;
    logic [11:0] ref_hsp_reg;
    logic [11:0] ref_hw_reg;
    logic [10:0] ref_vsp_reg;
    logic [10:0] ref_vw_reg;

    // Measurement output registers
    logic [11:0] m_htw_reg;
    logic [10:0] m_vtw_reg;
    logic [11:0] m_hsp_reg;
    logic [11:0] m_hw_reg;
    logic [10:0] m_vsp_reg;
    logic [10:0] m_vw_reg;
    logic [15:0] m_crc_reg;
    logic        frame_done_reg;

    assign frame_end   = HLOCK && VLOCK;
    assign timeout_hit = !HLOCK && (int'(to_cnt_reg) >= HTO - 1);

`ifdef SYNC_CRC_EN
    logic [15:0] crc_reg;
    logic [15:0] ref_crc_reg;

    // One 10-bit CRC-16-CCITT step, pixel MSB first
    function automatic logic [15:0] crc_step10(input logic [15:0] c, input logic [9:0] d);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int i = 9; i >= 0; i--) begin
            fb = r[15] ^ d[i];
            r  = {r[14:0], 1'b0};
            if (fb) begin
                r = r ^ 16'h1021;
            end
        end
        return r;
    endfunction

    assign fin_crc = SYNC_ACT ? crc_step10(crc_reg, SYNC_DO) : crc_reg;
    assign crc_eq  = (fin_crc == ref_crc_reg);

    // Running CRC over active pixels, restarted at every frame end
    always_ff @(posedge PCK) begin
        if (RST || frame_end) begin
            crc_reg <= 16'hFFFF;
        end else if (SYNC_ACT) begin
            crc_reg <= crc_step10(crc_reg, SYNC_DO);
        end
    end

    // Reference CRC captured whenever a new reference frame is stored
    always_ff @(posedge PCK) begin
        if (RST) begin
            ref_crc_reg <= 16'h0000;
        end else if (ref_load) begin
            ref_crc_reg <= fin_crc;
        end
    end
`else
    logic sync_do_unused;
    assign sync_do_unused = ^SYNC_DO;
    assign fin_crc        = 16'h0000;
    assign crc_eq         = 1'b1;
`endif

    // Free-running position counters and the HLOCK-loss watchdog
    always_ff @(posedge PCK) begin
        if (RST) begin
            hpos_reg   <= 12'd0;
            vpos_reg   <= 11'd0;
            to_cnt_reg <= 16'd0;
        end else begin
            if (HLOCK) begin
                hpos_reg <= 12'd0;
            end else if (hpos_reg != 12'hFFF) begin
                hpos_reg <= hpos_reg + 12'd1;
            end
            if (HLOCK) begin
                if (VLOCK) begin
                    vpos_reg <= 11'd0;
                end else if (vpos_reg != 11'h7FF) begin
                    vpos_reg <= vpos_reg + 11'd1;
                end
            end
            if (HLOCK) begin
                to_cnt_reg <= 16'd0;
            end else if (to_cnt_reg != 16'hFFFF) begin
                to_cnt_reg <= to_cnt_reg + 16'd1;
            end
        end
    end

    // Line start/width including the current cycle, so a pixel on the HLOCK cycle counts
    always_comb begin
        cur_hsp = line_hsp_reg;
        cur_hw  = line_hw_reg;
        if (SYNC_ACT) begin
            if (line_hw_reg == 12'd0) begin
                cur_hsp = hpos_reg;
            end
            if (line_hw_reg != 12'hFFF) begin
                cur_hw = line_hw_reg + 12'd1;
            end
        end
    end

    // Line capture registers, cleared at each line end
    always_ff @(posedge PCK) begin
        if (RST || HLOCK) begin
            line_hsp_reg <= 12'd0;
            line_hw_reg  <= 12'd0;
        end else begin
            line_hsp_reg <= cur_hsp;
            line_hw_reg  <= cur_hw;
        end
    end

    // Fold the ending line into the frame accumulators
    always_comb begin
        line_total = hpos_reg + 12'd1;
        a_lt       = fr_seen_reg ? fr_lt_reg : line_total;
        a_incons   = fr_incons_reg | (fr_seen_reg && (line_total != fr_lt_reg));
        a_act      = fr_act_reg;
        a_hsp      = fr_hsp_reg;
        a_hw       = fr_hw_reg;
        a_vsp      = fr_vsp_reg;
        a_vw       = fr_vw_reg;
        if (cur_hw != 12'd0) begin
            if (!fr_act_reg) begin
                a_act = 1'b1;
                a_hsp = cur_hsp;
                a_hw  = cur_hw;
                a_vsp = vpos_reg;
                a_vw  = 11'd1;
            end else begin
                if (fr_vw_reg != 11'h7FF) begin
                    a_vw = fr_vw_reg + 11'd1;
                end
                if ((cur_hsp != fr_hsp_reg) || (cur_hw != fr_hw_reg)) begin
                    a_incons = 1'b1;
                end
            end
        end
        fin_htw  = line_total;
        fin_vtw  = vpos_reg + 11'd1;
        frame_eq = (fin_htw == ref_htw_reg) && (fin_vtw == ref_vtw_reg) &&
                   (a_hsp == ref_hsp_reg) && (a_hw == ref_hw_reg) &&
                   (a_vsp == ref_vsp_reg) && (a_vw == ref_vw_reg);
    end

    // Frame accumulators: load at each line end, clear at each frame end
    always_ff @(posedge PCK) begin
        if (RST || frame_end) begin
            fr_seen_reg   <= 1'b0;
            fr_lt_reg     <= 12'd0;
            fr_act_reg    <= 1'b0;
            fr_hsp_reg    <= 12'd0;
            fr_hw_reg     <= 12'd0;
            fr_vsp_reg    <= 11'd0;
            fr_vw_reg     <= 11'd0;
            fr_incons_reg <= 1'b0;
        end else if (HLOCK) begin
            fr_seen_reg   <= 1'b1;
            fr_lt_reg     <= a_lt;
            fr_act_reg    <= a_act;
            fr_hsp_reg    <= a_hsp;
            fr_hw_reg     <= a_hw;
            fr_vsp_reg    <= a_vsp;
            fr_vw_reg     <= a_vw;
            fr_incons_reg <= a_incons;
        end
    end

    // FSM state and statistics registers
    always_ff @(posedge PCK) begin
        if (RST) begin
            state_reg   <= S_IDLE;
            match_reg   <= 4'd0;
            err_reg     <= 8'd0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            match_reg   <= match_next;
            err_reg     <= err_next;
            timeout_reg <= timeout_next;
        end
    end

    // Next-state: timeout overrides, otherwise evaluate at each frame end
    always_comb begin
        state_next   = state_reg;
        match_next   = match_reg;
        err_next     = err_reg;
        timeout_next = timeout_reg;
        ref_load     = 1'b0;
        upd_m        = 1'b0;
        if (timeout_hit) begin
            timeout_next = 1'b1;
            state_next   = S_IDLE;
            if ((state_reg == S_LOCKED) && (err_reg != 8'hFF)) begin
                err_next = err_reg + 8'd1;
            end
        end else if (frame_end) begin
            case (state_reg)
                S_IDLE: begin
                    state_next = S_MEASURE;
                end
                S_MEASURE: begin
                    upd_m      = 1'b1;
                    ref_load   = 1'b1;
                    match_next = 4'd1;
                    state_next = (LOCK_FRAMES <= 1) ? S_LOCKED : S_VERIFY;
                end
                S_VERIFY: begin
                    upd_m = 1'b1;
                    if (frame_eq && !a_incons) begin
                        match_next = match_reg + 4'd1;
                        if (int'(match_reg) + 1 >= LOCK_FRAMES) begin
                            state_next = S_LOCKED;
                        end
                    end else begin
                        ref_load   = 1'b1;
                        match_next = 4'd1;
                    end
                end
                S_LOCKED: begin
                    upd_m = 1'b1;
                    if (!(frame_eq && crc_eq && !a_incons)) begin
                        ref_load   = 1'b1;
                        match_next = 4'd1;
                        state_next = S_VERIFY;
                        if (err_reg != 8'hFF) begin
                            err_next = err_reg + 8'd1;
                        end
                    end
                end
                default: begin
                    state_next = S_IDLE;
                end
            endcase
        end
    end

    // Reference frame storage
    always_ff @(posedge PCK) begin
        if (RST) begin
            ref_htw_reg <= 12'd0;
            ref_vtw_reg <= 11'd0;
            ref_hsp_reg <= 12'd0;
            ref_hw_reg  <= 12'd0;
            ref_vsp_reg <= 11'd0;
            ref_vw_reg  <= 11'd0;
        end else if (ref_load) begin
            ref_htw_reg <= fin_htw;
            ref_vtw_reg <= fin_vtw;
            ref_hsp_reg <= a_hsp;
            ref_hw_reg  <= a_hw;
            ref_vsp_reg <= a_vsp;
            ref_vw_reg  <= a_vw;
        end
    end

    // Measurement outputs and FRAME_DONE, the cycle after a processed frame end
    always_ff @(posedge PCK) begin
        if (RST) begin
            m_htw_reg      <= 12'd0;
            m_vtw_reg      <= 11'd0;
            m_hsp_reg      <= 12'd0;
            m_hw_reg       <= 12'd0;
            m_vsp_reg      <= 11'd0;
            m_vw_reg       <= 11'd0;
            m_crc_reg      <= 16'd0;
            frame_done_reg <= 1'b0;
        end else begin
            frame_done_reg <= upd_m;
            if (upd_m) begin
                m_htw_reg <= fin_htw;
                m_vtw_reg <= fin_vtw;
                m_hsp_reg <= a_hsp;
                m_hw_reg  <= a_hw;
                m_vsp_reg <= a_vsp;
                m_vw_reg  <= a_vw;
                m_crc_reg <= fin_crc;
            end
        end
    end

    assign M_HTW      = m_htw_reg;
    assign M_VTW      = m_vtw_reg;
    assign M_HSP      = m_hsp_reg;
    assign M_HW       = m_hw_reg;
    assign M_VSP      = m_vsp_reg;
    assign M_VW       = m_vw_reg;
    assign M_CRC      = m_crc_reg;
    assign FRAME_DONE = frame_done_reg;
    assign LOCKED     = (state_reg == S_LOCKED);
    assign ERR_CNT    = err_reg;
    assign TIMEOUT    = timeout_reg;

endmodule

// File: tb/tb_sync_timing_rx.sv
// Testbench for sync_timing_rx: drives randomized rasters frame by frame and
// checks the measurements and lock status against a frame-level model.
module tb_sync_timing_rx;

    localparam int LF = 2;

    logic        PCK = 1'b0;
    logic        RST;
    logic        HLOCK;
    logic        VLOCK;
    logic        SYNC_ACT;
    logic [9:0]  SYNC_DO;
    logic [11:0] M_HTW;
    logic [10:0] M_VTW;
    logic [11:0] M_HSP;
    logic [11:0] M_HW;
    logic [10:0] M_VSP;
    logic [10:0] M_VW;
    logic        FRAME_DONE;
    logic        LOCKED;
    logic [7:0]  ERR_CNT;
    logic        TIMEOUT;
    logic [15:0] M_CRC;

    sync_timing_rx #(.LOCK_FRAMES(LF), .HTO(4095)) dut (
        .PCK(PCK), .RST(RST), .HLOCK(HLOCK), .VLOCK(VLOCK),
        .SYNC_ACT(SYNC_ACT), .SYNC_DO(SYNC_DO),
        .M_HTW(M_HTW), .M_VTW(M_VTW), .M_HSP(M_HSP), .M_HW(M_HW),
        .M_VSP(M_VSP), .M_VW(M_VW), .FRAME_DONE(FRAME_DONE), .LOCKED(LOCKED),
        .ERR_CNT(ERR_CNT), .TIMEOUT(TIMEOUT), .M_CRC(M_CRC)
    );

    always #5 PCK = ~PCK;

    int n_tests = 0;
    int n_fail  = 0;

    // Current raster description
    int         r_ht, r_vt, r_hs, r_hw, r_vs, r_vw;
    logic [9:0] r_seed;

    // Frame-level model state
    bit          m_aligned, m_locked, m_timeout;
    int          m_run, m_err;
    int          ref_sig[6];
    logic [15:0] ref_crc;
    int          exp_m[6];
    logic [15:0] exp_mcrc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] crc10(input logic [15:0] c, input logic [9:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 9; i >= 0; i--) begin
            if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
            else              r = {r[14:0], 1'b0};
        end
        return r;
    endfunction

    function automatic logic [9:0] pix(input int h, input int v);
        int s;
        s = h * 37 + v * 11 + int'(r_seed);
        return s[9:0];
    endfunction

    task automatic model_reset();
        m_aligned = 0; m_locked = 0; m_timeout = 0; m_run = 0; m_err = 0;
        for (int i = 0; i < 6; i++) begin
            exp_m[i] = 0; ref_sig[i] = 0;
        end
        exp_mcrc = 16'h0; ref_crc = 16'h0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_m"}, {M_HTW, M_VTW, M_HSP, M_HW, M_VSP, M_VW}, 0);
        chk({tag, "_m2"}, 32'(M_VW) | 32'(M_CRC), 0);
        chk({tag, "_fd"}, 32'(FRAME_DONE), 0);
        chk({tag, "_locked"}, 32'(LOCKED), 0);
        chk({tag, "_err"}, 32'(ERR_CNT), 0);
        chk({tag, "_timeout"}, 32'(TIMEOUT), 0);
    endtask

    // mode: 0 clean, 1 one line one cycle longer, 2 one active line one pixel
    // narrower, 3 one active pixel value corrupted
    task automatic drive_frame(input int mode, input int bad_line, input int abort_at,
                               output int fds, output logic [15:0] crc);
        int cyc;
        fds = 0; crc = 16'hFFFF; cyc = 0;
        for (int v = 0; v < r_vt; v++) begin
            int len;
            len = r_ht + ((mode == 1 && v == bad_line) ? 1 : 0);
            for (int h = 0; h < len; h++) begin
                bit         act;
                logic [9:0] d;
                act = (v >= r_vs) && (v < r_vs + r_vw) && (h >= r_hs) && (h < r_hs + r_hw);
                if (mode == 2 && v == bad_line && h == r_hs + r_hw - 1) act = 0;
                d = pix(h, v);
                if (mode == 3 && v == bad_line && h == r_hs) d = d ^ 10'h001;
                if (cyc == abort_at) begin
                    RST = 1; HLOCK = 0; VLOCK = 0; SYNC_ACT = 0;
                    @(posedge PCK); #1;
                    return;
                end
                HLOCK    = (h == len - 1);
                VLOCK    = (h == len - 1) && (v == r_vt - 1);
                SYNC_ACT = act;
                SYNC_DO  = d;
                if (act) crc = crc10(crc, d);
                @(posedge PCK); #1;
                if (FRAME_DONE) fds++;
                cyc++;
            end
        end
    endtask

    task automatic run_frame(input int mode, input int bad_line);
        int          fds;
        logic [15:0] crc;
        int          sig[6];
        bit          incons, same, first, exp_fd;
        drive_frame(mode, bad_line, -1, fds, crc);
        sig[0] = r_ht; sig[1] = r_vt;
        if (r_hw > 0 && r_vw > 0) begin
            sig[2] = r_hs; sig[3] = r_hw; sig[4] = r_vs; sig[5] = r_vw;
        end else begin
            sig[2] = 0; sig[3] = 0; sig[4] = 0; sig[5] = 0;
        end
        incons = (mode == 1) || (mode == 2);
        exp_fd = m_aligned;
        if (!m_aligned) begin
            m_aligned = 1;
        end else begin
            first = (m_run == 0);
            same  = !first && !incons;
            for (int i = 0; i < 6; i++) if (sig[i] != ref_sig[i]) same = 0;
`ifdef SYNC_CRC_EN
            if (m_locked && crc != ref_crc) same = 0;
`endif
            if (same) begin
                m_run++;
                m_locked = (m_run >= LF);
            end else begin
                if (m_locked && m_err < 255) m_err++;
                ref_sig  = sig;
                ref_crc  = crc;
                m_run    = 1;
                m_locked = first && (LF == 1);
            end
            exp_m = sig;
`ifdef SYNC_CRC_EN
            exp_mcrc = crc;
`endif
        end
        $display("[TB] frame mode=%0d raster=%0dx%0d act=(%0d,%0d,%0d,%0d) fd=%0d locked=%0d err=%0d",
                 mode, r_ht, r_vt, r_hs, r_hw, r_vs, r_vw, fds, LOCKED, ERR_CNT);
        chk("frame_done_count", fds, 32'(exp_fd));
        chk("LOCKED", 32'(LOCKED), 32'(m_locked));
        chk("ERR_CNT", 32'(ERR_CNT), m_err);
        chk("TIMEOUT", 32'(TIMEOUT), 32'(m_timeout));
        chk("M_HTW", 32'(M_HTW), exp_m[0]);
        chk("M_VTW", 32'(M_VTW), exp_m[1]);
        chk("M_HSP", 32'(M_HSP), exp_m[2]);
        chk("M_HW", 32'(M_HW), exp_m[3]);
        chk("M_VSP", 32'(M_VSP), exp_m[4]);
        chk("M_VW", 32'(M_VW), exp_m[5]);
        chk("M_CRC", 32'(M_CRC), 32'(exp_mcrc));
    endtask

    task automatic new_raster();
        r_ht   = $urandom_range(48, 24);
        r_vt   = $urandom_range(12, 6);
        r_hs   = $urandom_range(r_ht - 3, 0);
        r_hw   = $urandom_range(r_ht - r_hs, 2);
        r_vs   = $urandom_range(r_vt - 3, 0);
        r_vw   = $urandom_range(r_vt - r_vs, 2);
        r_seed = 10'($urandom);
    endtask

    initial begin
        int          fds;
        logic [15:0] crc;

        RST = 1; HLOCK = 0; VLOCK = 0; SYNC_ACT = 0; SYNC_DO = 10'd0;
        model_reset();
        repeat (3) @(posedge PCK);
        #1;
        chk_all_zero("reset");
        $display("[TB] reset released");
        RST = 0;

        // Acquire lock on a random raster
        new_raster();
        repeat (4) run_frame(0, 0);

        // One line one cycle longer while locked, then two clean frames
        run_frame(1, $urandom_range(r_vt - 2, 1));
        repeat (2) run_frame(0, 0);

        // One active line narrower while locked
        run_frame(2, r_vs + r_vw - 1);
        repeat (2) run_frame(0, 0);

        // Active window reaching the last pixel and last line
        r_hs = $urandom_range(r_ht - 3, 0); r_hw = r_ht - r_hs;
        r_vs = $urandom_range(r_vt - 3, 0); r_vw = r_vt - r_vs;
        repeat (3) run_frame(0, 0);

        // One corrupted pixel while locked (matters only with the CRC built in)
        run_frame(3, r_vs);
        repeat (2) run_frame(0, 0);

        // HLOCK lost for 5000 cycles while locked
        for (int i = 1; i <= 5000; i++) begin
            HLOCK = 0; VLOCK = 0; SYNC_ACT = 0;
            @(posedge PCK); #1;
            if (i == 4094) begin
                chk("timeout_early", 32'(TIMEOUT), 0);
                chk("locked_before_timeout", 32'(LOCKED), 32'(m_locked));
            end
            if (i == 4095) begin
                chk("timeout_set", 32'(TIMEOUT), 1);
                chk("locked_after_timeout", 32'(LOCKED), 0);
                chk("err_after_timeout", 32'(ERR_CNT), m_err + (m_locked ? 1 : 0));
                $display("[TB] timeout at cycle %0d timeout=%0d locked=%0d err=%0d", i, TIMEOUT, LOCKED, ERR_CNT);
            end
        end
        if (m_locked) m_err++;
        m_locked = 0; m_aligned = 0; m_run = 0; m_timeout = 1;
        repeat (3) run_frame(0, 0);

        // Raster with no active pixels
        r_ht = 100; r_vt = 10; r_hs = 0; r_hw = 0; r_vs = 0; r_vw = 0;
        repeat (3) run_frame(0, 0);

        // Reset mid-frame while locked
        new_raster();
        repeat (3) run_frame(0, 0);
        drive_frame(0, 0, $urandom_range(r_ht * r_vt - 2, r_ht), fds, crc);
        chk_all_zero("midframe_reset");
        $display("[TB] mid-frame reset applied");
        RST = 0;
        model_reset();
        repeat (3) run_frame(0, 0);

        // A few more random rasters
        for (int k = 0; k < 3; k++) begin
            new_raster();
            repeat (3) run_frame(0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
